lcd_host: RTL and testbench

LCD_HOST -- requirements
Module: lcd_host

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_host_if.sv | 15 +
 rtl/lcd_host_outbuf.sv | 50 +++++
 rtl/lcd_host.sv | 137 +++++++++++++
 tb/tb_lcd_host.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD host: command codes, FSM encoding, frame/result sizes.
package lcd_pkg;
   localparam int FRAME_BYTES = 64;
   localparam int OUT_PIXELS  = 16;

   localparam logic [2:0] CMD_REFLASH  = 3'd0;
   localparam logic [2:0] CMD_LOAD     = 3'd1;
   localparam logic [2:0] CMD_ZOOM_IN  = 3'd2;
   localparam logic [2:0] CMD_ZOOM_OUT = 3'd3;
   localparam logic [2:0] CMD_RIGHT    = 3'd4;
   localparam logic [2:0] CMD_LEFT     = 3'd5;
   localparam logic [2:0] CMD_UP       = 3'd6;
   localparam logic [2:0] CMD_DOWN     = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_LOAD,
      ST_WAIT,
      ST_DRAIN
   } state_t;
endpackage

// File: rtl/lcd_host_if.sv
// Command request and pixel result handshakes between a client and lcd_host.
interface lcd_host_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_cmd;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [3:0] res_idx;

   modport master (output req_valid, req_cmd, res_ready,
                   input  req_ready, res_valid, res_data, res_idx);
   modport slave  (input  req_valid, req_cmd, res_ready,
                   output req_ready, res_valid, res_data, res_idx);
endinterface

// File: rtl/lcd_host_outbuf.sv
// 16x8 pixel capture buffer: saturating write index plus a sequential drain read port.
// LCD_HOST_CHECK_EN exposes the post-write capture count for the short-frame check.
module lcd_host_outbuf
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_adv,
   output logic [3:0] rd_idx,
   output logic [7:0] rd_data
`ifdef LCD_HOST_CHECK_EN
   ,
   output logic [4:0] cap_next
`endif
);

   logic [OUT_PIXELS-1:0][7:0] mem;
   logic [4:0]                 cap_cnt;
   logic                       wr_ok;

   // Count runs 0..16; anything past the 16th capture is dropped.
   assign wr_ok = wr_en && (cap_cnt != 5'(OUT_PIXELS));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_cnt <= '0;
         rd_idx  <= '0;
      end else if (clr) begin
         cap_cnt <= '0;
         rd_idx  <= '0;
      end else begin
         if (wr_ok)  cap_cnt <= cap_cnt + 5'd1;
         if (rd_adv) rd_idx  <= rd_idx + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[cap_cnt[3:0]] <= wr_data;
   end

   assign rd_data = mem[rd_idx];

`ifdef LCD_HOST_CHECK_EN
   assign cap_next = wr_ok ? cap_cnt + 5'd1 : cap_cnt;
`endif

endmodule

// File: rtl/lcd_host.sv
// LCD host: accepts commands, streams a 64-byte ROM frame on load, captures 16 pixels, drains them.
// Optional LCD_HOST_CHECK_EN adds short-frame and idle output_valid protocol error pulses.
module lcd_host
   import lcd_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           reset,
   lcd_host_if.slave      bus,
   output logic           img_rd,
   output logic [5:0]     img_addr,
   input  logic [7:0]     img_data,
   output logic [2:0]     cmd,
   output logic           cmd_valid,
   output logic [7:0]     datain,
   input  logic           busy,
   input  logic           output_valid,
   input  logic [7:0]     dataout,
   output logic           err
);

   localparam int         TW   = $clog2(TIMEOUT + 1);
   localparam logic [5:0] LAST = 6'(FRAME_BYTES - 1);

   state_t          state;
   logic [5:0]      load_cnt;
   logic [TW-1:0]   wait_cnt;
   logic            idle_ready;
   logic            buf_clr;
   logic [3:0]      rd_idx;
   logic [7:0]      rd_data;
`ifdef LCD_HOST_CHECK_EN
   logic [4:0]      cap_next;
`endif

   assign idle_ready    = (state == ST_IDLE) && !busy;
   assign bus.req_ready = idle_ready && !reset;
   assign datain        = (state == ST_LOAD) ? img_data : 8'd0;

   // Buffer is cleared on every entry into WAIT, which also discards a timed-out frame.
   assign buf_clr = ((state == ST_ISSUE) && (cmd != CMD_LOAD)) ||
                    ((state == ST_LOAD)  && (load_cnt == LAST));

   assign bus.res_valid = (state == ST_DRAIN);
   assign bus.res_data  = bus.res_valid ? rd_data : 8'd0;
   assign bus.res_idx   = bus.res_valid ? rd_idx  : 4'd0;

   lcd_host_outbuf u_outbuf (
      .clk     (clk),
      .reset   (reset),
      .clr     (buf_clr),
      .wr_en   ((state == ST_WAIT) && output_valid),
      .wr_data (dataout),
      .rd_adv  ((state == ST_DRAIN) && bus.res_ready),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
`ifdef LCD_HOST_CHECK_EN
      ,
      .cap_next(cap_next)
`endif
   );

   // cmd holds the latched code only during ISSUE, so it also steers the ISSUE branch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cmd       <= '0;
         cmd_valid <= 1'b0;
         img_rd    <= 1'b0;
         img_addr  <= '0;
         err       <= 1'b0;
         load_cnt  <= '0;
         wait_cnt  <= '0;
      end else begin
         cmd       <= '0;
         cmd_valid <= 1'b0;
         img_rd    <= 1'b0;
         img_addr  <= '0;
         err       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req_valid && idle_ready) begin
                  state     <= ST_ISSUE;
                  cmd       <= bus.req_cmd;
                  cmd_valid <= 1'b1;
                  img_rd    <= (bus.req_cmd == CMD_LOAD);
               end
`ifdef LCD_HOST_CHECK_EN
               if (output_valid) err <= 1'b1;
`endif
            end
            ST_ISSUE: begin
               if (cmd == CMD_LOAD) begin
                  state    <= ST_LOAD;
                  load_cnt <= '0;
                  img_rd   <= 1'b1;
                  img_addr <= 6'd1;
               end else begin
                  state    <= ST_WAIT;
                  wait_cnt <= '0;
               end
            end
            ST_LOAD: begin
               load_cnt <= load_cnt + 6'd1;
               // Prefetch two ahead: the ROM answers one cycle after img_rd.
               if (load_cnt < LAST - 6'd1) begin
                  img_rd   <= 1'b1;
                  img_addr <= load_cnt + 6'd2;
               end
               if (load_cnt == LAST) begin
                  state    <= ST_WAIT;
                  wait_cnt <= '0;
               end
            end
            ST_WAIT: begin
               if (!busy) begin
                  state <= ST_DRAIN;
`ifdef LCD_HOST_CHECK_EN
                  if (cap_next != 5'(OUT_PIXELS)) err <= 1'b1;
`endif
               end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                  state <= ST_IDLE;
                  err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (bus.res_ready && (rd_idx == 4'(OUT_PIXELS - 1))) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_host.sv
// Directed bench for lcd_host: ROM model returns ROM[k]=k, LCD side is scripted per test.
// Expected error pulses follow LCD_HOST_CHECK_EN when it is defined for the build.
module tb_lcd_host;

   localparam int TO = 40;
`ifdef LCD_HOST_CHECK_EN
   localparam int EXP_CHK = 1;
`else
   localparam int EXP_CHK = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       img_rd;
   logic [5:0] img_addr;
   logic [7:0] img_data = 8'd0;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic [7:0] datain;
   logic       busy = 1'b0;
   logic       output_valid = 1'b0;
   logic [7:0] dataout = 8'd0;
   logic       err;

   int n_chk = 0;
   int n_pass = 0;

   lcd_host_if bus();

   lcd_host #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .img_rd       (img_rd),
      .img_addr     (img_addr),
      .img_data     (img_data),
      .cmd          (cmd),
      .cmd_valid    (cmd_valid),
      .datain       (datain),
      .busy         (busy),
      .output_valid (output_valid),
      .dataout      (dataout),
      .err          (err)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (img_rd) img_data <= {2'b00, img_addr};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, ".cmd_valid"}, cmd_valid, 0);
      chk({tag, ".cmd"},       cmd, 0);
      chk({tag, ".datain"},    datain, 0);
      chk({tag, ".img_rd"},    img_rd, 0);
      chk({tag, ".img_addr"},  img_addr, 0);
      chk({tag, ".res_valid"}, bus.res_valid, 0);
      chk({tag, ".res_data"},  bus.res_data, 0);
      chk({tag, ".res_idx"},   bus.res_idx, 0);
      chk({tag, ".err"},       err, 0);
      chk({tag, ".req_ready"}, bus.req_ready, 0);
   endtask

   // Leaves the bench positioned in the ISSUE cycle.
   task automatic issue(input logic [2:0] c);
      nxt();
      bus.req_valid = 1'b1; bus.req_cmd = c; busy = 1'b0;
      @(negedge clk);
      chk("req_ready", bus.req_ready, 1);
      nxt();
      bus.req_valid = 1'b0; busy = 1'b1;
      @(negedge clk);
      chk("issue.cmd_valid", cmd_valid, 1);
      chk("issue.cmd", cmd, c);
   endtask

   task automatic load_frame(input int n);
      for (int k = 0; k < n; k++) begin
         nxt();
         @(negedge clk);
         chk("load.datain", datain, k);
         if (k == 0)  chk("load.addr0", img_addr, 1);
         if (k == 63) chk("load.rd_last", img_rd, 0);
      end
   endtask

   // LCD returns n pixels on consecutive cycles, dropping busy with the last one.
   task automatic lcd_return(input int n, input logic [7:0] base);
      for (int j = 0; j < n; j++) begin
         nxt();
         output_valid = 1'b1;
         dataout = 8'(base + j);
         busy = (j != n - 1);
      end
   endtask

   task automatic drain(input logic [7:0] base, input int n_data, input bit toggle, input int exp_err);
      int got, errs, cyc;
      got = 0; errs = 0; cyc = 0;
      while (got < 16 && cyc < 200) begin
         nxt();
         output_valid = 1'b0; busy = 1'b0;
         bus.res_ready = toggle ? cyc[0] : 1'b1;
         @(negedge clk);
         if (err) errs++;
         if (bus.res_valid && bus.res_ready) begin
            chk("res_idx", bus.res_idx, got);
            if (got < n_data) chk("res_data", bus.res_data, 8'(base + got));
            got++;
         end
         cyc++;
      end
      chk("drain.count", got, 16);
      nxt();
      bus.res_ready = 1'b0;
      @(negedge clk);
      if (err) errs++;
      chk("drain.done", bus.res_valid, 0);
      chk("drain.err", errs, exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit seen;
      bus.req_valid = 1'b0; bus.req_cmd = 3'd0; bus.res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_rst("rst");

      // Request held while busy, then accepted once busy drops; full frame load.
      nxt();
      reset = 1'b0; busy = 1'b1; bus.req_valid = 1'b1; bus.req_cmd = 3'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("busy.req_ready", bus.req_ready, 0);
         chk("busy.cmd_valid", cmd_valid, 0);
         nxt();
      end
      busy = 1'b0;
      @(negedge clk);
      chk("free.req_ready", bus.req_ready, 1);
      nxt();
      bus.req_valid = 1'b0; busy = 1'b1;
      @(negedge clk);
      chk("load.cmd_valid", cmd_valid, 1);
      chk("load.cmd", cmd, 1);
      chk("load.img_rd", img_rd, 1);
      chk("load.img_addr", img_addr, 0);
      load_frame(64);
      lcd_return(16, 8'h10);
      drain(8'h10, 16, 1'b0, 0);

      // Zoom-in with a 50% res_ready pattern.
      issue(3'd2);
      lcd_return(16, 8'h40);
      drain(8'h40, 16, 1'b1, 0);

      // Busy forever: timeout.
      issue(3'd3);
      n = 0; seen = 1'b0;
      while (!seen && n < 3 * TO) begin
         nxt();
         busy = 1'b1;
         @(negedge clk);
         n++;
         if (err) seen = 1'b1;
      end
      chk("timeout.seen", seen, 1);
      chk("timeout.lat", n - 1, TO);
      nxt();
      busy = 1'b0;
      @(negedge clk);
      chk("timeout.pulse", err, 0);
      chk("timeout.idle", bus.req_ready, 1);

      // Short frame: 15 pixels.
      issue(3'd4);
      lcd_return(15, 8'h80);
      drain(8'h80, 15, 1'b0, EXP_CHK);

      // Long frame: 18 pixels, extras dropped.
      issue(3'd6);
      lcd_return(18, 8'hA0);
      drain(8'hA0, 16, 1'b1, 0);

      // output_valid while idle.
      nxt();
      output_valid = 1'b1;
      @(negedge clk);
      nxt();
      output_valid = 1'b0;
      @(negedge clk);
      chk("idle.err", err, EXP_CHK);

      // Reset mid-load, then a normal transaction.
      issue(3'd1);
      load_frame(10);
      nxt();
      reset = 1'b1; busy = 1'b0;
      @(negedge clk);
      chk_rst("midrst");
      nxt();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst.err", err, 0);
      issue(3'd5);
      lcd_return(16, 8'hC0);
      drain(8'hC0, 16, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
